// File: rtl/vector_add_stream.sv
// Streaming signed vector add/sub: LANES elements per beat, one register stage,
// per-vector mode latch, optional saturation and a sticky per-vector overflow flag.
//
// state | meaning
// IDLE  | cnt_q == 0: next accepted beat is beat 0 and samples op_sub/op_sat
// BUSY  | cnt_q != 0: mid-vector, mode_q governs the arithmetic
module vector_add_stream #(
  parameter  int DATA_W  = 32,
  parameter  int VEC_LEN = 400,
  parameter  int LANES   = 4,
  localparam int BEATS   = VEC_LEN / LANES,
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_a,
  input  logic [LANES*DATA_W-1:0]   in_b,
  input  logic                      op_sub,
  input  logic                      op_sat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [BEAT_W-1:0]         out_beat,
  output logic                      out_last,
  output logic                      out_ovf
);

  if ((VEC_LEN % LANES) != 0 || VEC_LEN < LANES) begin : g_bad_cfg
    $error("vector_add_stream: VEC_LEN must be a non-zero multiple of LANES");
  end

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [BEAT_W-1:0] LAST_CNT = BEAT_W'(BEATS - 1);

  logic [BEAT_W-1:0]       cnt_q;
  logic                    mode_sub_q, mode_sat_q;
  logic                    ovf_acc_q;
  logic                    out_valid_q;
  logic [LANES*DATA_W-1:0] out_data_q;
  logic [BEAT_W-1:0]       out_beat_q;
  logic                    out_last_q;
  logic                    out_ovf_q;

  logic                    xfer_in;
  logic                    first_beat, last_beat;
  logic                    sub_eff, sat_eff;
  logic [LANES*DATA_W-1:0] res_d;
  logic [LANES-1:0]        lane_ovf;
  logic                    acc_d;
  logic [DATA_W:0]         a_ext, b_ext, exact;

  assign in_ready   = !out_valid_q || out_ready;
  assign xfer_in    = in_valid && in_ready;
  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == LAST_CNT);
  assign sub_eff    = first_beat ? op_sub : mode_sub_q;
  assign sat_eff    = first_beat ? op_sat : mode_sat_q;

  // Overflow shows up as disagreement between the two top bits of the exact sum.
  always_comb begin
    res_d    = '0;
    lane_ovf = '0;
    a_ext    = '0;
    b_ext    = '0;
    exact    = '0;
    for (int i = 0; i < LANES; i++) begin
      a_ext = {in_a[i*DATA_W + DATA_W - 1], in_a[i*DATA_W +: DATA_W]};
      b_ext = {in_b[i*DATA_W + DATA_W - 1], in_b[i*DATA_W +: DATA_W]};
      exact = sub_eff ? (a_ext - b_ext) : (a_ext + b_ext);
      lane_ovf[i] = exact[DATA_W] ^ exact[DATA_W-1];
      if (lane_ovf[i] && sat_eff)
        res_d[i*DATA_W +: DATA_W] = exact[DATA_W] ? MIN_NEG : MAX_POS;
      else
        res_d[i*DATA_W +: DATA_W] = exact[DATA_W-1:0];
    end
  end

  assign acc_d = ovf_acc_q | (|lane_ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mode_sub_q  <= 1'b0;
      mode_sat_q  <= 1'b0;
      ovf_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beat_q  <= '0;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (xfer_in) begin
      if (first_beat) begin
        mode_sub_q <= op_sub;
        mode_sat_q <= op_sat;
      end
      cnt_q       <= last_beat ? '0 : cnt_q + BEAT_W'(1);
      ovf_acc_q   <= last_beat ? 1'b0 : acc_d;
      out_valid_q <= 1'b1;
      out_data_q  <= res_d;
      out_beat_q  <= cnt_q;
      out_last_q  <= last_beat;
      out_ovf_q   <= last_beat & acc_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_beat  = out_beat_q;
  assign out_last  = out_last_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_vector_add_stream.sv
// Scoreboard bench for vector_add_stream (DATA_W=32, VEC_LEN=8, LANES=4):
// directed hand-computed vectors plus a randomised valid/ready run against a model.
module tb_vector_add_stream;

  localparam int DW = 32;
  localparam int LN = 4;
  localparam int W  = DW * LN;

  logic         clk, rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         op_sub, op_sat;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data;
  logic [0:0]   out_beat;
  logic         out_last, out_ovf;

  vector_add_stream #(.DATA_W(DW), .VEC_LEN(8), .LANES(LN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .op_sub(op_sub), .op_sat(op_sat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beat(out_beat), .out_last(out_last), .out_ovf(out_ovf)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         beat;
    logic         last;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  bit   rand_ready = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] p4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic void model(input logic [W-1:0] a, b, input logic sub, sat,
                                output logic [W-1:0] r, output logic ov);
    longint maxv = 64'sd2147483647;
    longint minv = -64'sd2147483648;
    r  = '0;
    ov = 0;
    for (int i = 0; i < LN; i++) begin
      logic signed [31:0] x, y;
      longint e;
      logic lo;
      x  = a[i*32 +: 32];
      y  = b[i*32 +: 32];
      e  = sub ? longint'(x) - longint'(y) : longint'(x) + longint'(y);
      lo = (e > maxv) || (e < minv);
      ov |= lo;
      r[i*32 +: 32] = (lo && sat) ? ((e > 0) ? 32'h7fffffff : 32'h80000000) : e[31:0];
    end
  endfunction

  // Monitor: pops an expectation on every output transfer
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_output: got beat %0d data %h expected nothing", out_beat, out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_beat", W'(out_beat), W'(e.beat));
          check("out_last", W'(out_last), W'(e.last));
          if (e.last) check("out_ovf", W'(out_ovf), W'(e.ovf));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // All tasks start and end 1 time unit after a rising edge
  task automatic wait_accept();
    int  n = 0;
    bit  ok = 0;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (++n > 1000) begin
        total_cnt++;
        $display("FAIL accept_timeout: got in_ready stuck low expected acceptance");
        ok = 1;
      end
    end
    in_valid = 0;
  endtask

  task automatic send(input logic [W-1:0] a, b, input logic sub, sat,
                      input logic [W-1:0] ed, input logic eb, el, eo);
    exp_t e;
    e.data = ed; e.beat = eb; e.last = el; e.ovf = eo;
    sb.push_back(e);
    in_a = a; in_b = b; op_sub = sub; op_sat = sat; in_valid = 1;
    wait_accept();
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) begin
      total_cnt++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb, rr;
    logic         rov, acc, vsub, vsat;

    rst_n = 0; in_valid = 0; in_a = '0; in_b = '0; op_sub = 0; op_sat = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, '0);
    check("rst_out_last_ovf", W'({out_last, out_ovf, out_beat}), W'(0));
    rst_n = 1;
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;

    // Wrap add with one-cycle latency
    send(p4(1, 2, 3, 4), p4(10, 10, 10, 10), 0, 0, p4(11, 12, 13, 14), 0, 0, 0);
    check("latency_valid", W'(out_valid), W'(1));
    check("latency_data", out_data, p4(11, 12, 13, 14));
    send(p4(5, 6, 7, 8), p4(10, 10, 10, 10), 0, 0, p4(15, 16, 17, 18), 1, 1, 0);

    // Saturating add, then saturating sub; overflow only on beat 0
    send(p4(32'h7fffffff, 0, 0, 0), p4(1, 0, 0, 0), 0, 1, p4(32'h7fffffff, 0, 0, 0), 0, 0, 0);
    send(p4(5, 5, 5, 5), p4(1, 1, 1, 1), 0, 0, p4(6, 6, 6, 6), 1, 1, 1);
    send(p4(32'h80000000, 9, 0, 0), p4(1, 4, 0, 0), 1, 1, p4(32'h80000000, 5, 0, 0), 0, 0, 0);
    send(p4(5, 5, 5, 5), p4(1, 1, 1, 1), 0, 0, p4(4, 4, 4, 4), 1, 1, 1);

    // Wrap overflow, then a clean vector must report no overflow
    send(p4(32'h7fffffff, 1, 2, 3), p4(1, 1, 1, 1), 0, 0, p4(32'h80000000, 2, 3, 4), 0, 0, 0);
    send(p4(0, 0, 0, 0), p4(0, 0, 0, 0), 0, 0, p4(0, 0, 0, 0), 1, 1, 1);
    send(p4(1, 1, 1, 1), p4(2, 2, 2, 2), 0, 0, p4(3, 3, 3, 3), 0, 0, 0);
    send(p4(1, 1, 1, 1), p4(2, 2, 2, 2), 0, 0, p4(3, 3, 3, 3), 1, 1, 0);

    // Mode lock: op_sub dropped on beat 1 must be ignored
    send(p4(10, 10, 10, 10), p4(3, 3, 3, 3), 1, 0, p4(7, 7, 7, 7), 0, 0, 0);
    send(p4(5, 5, 5, 5), p4(7, 7, 7, 7), 0, 0, p4(32'hfffffffe, 32'hfffffffe, 32'hfffffffe, 32'hfffffffe), 1, 1, 0);

    // Backpressure: out_ready low for 3 cycles with beat 1 waiting
    drain();
    out_ready = 0;
    send(p4(100, 100, 100, 100), p4(1, 1, 1, 1), 0, 0, p4(101, 101, 101, 101), 0, 0, 0);
    begin
      exp_t e;
      e.data = p4(201, 201, 201, 201); e.beat = 1; e.last = 1; e.ovf = 0;
      sb.push_back(e);
    end
    in_a = p4(200, 200, 200, 200); in_b = p4(1, 1, 1, 1); op_sub = 1; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", W'(in_ready), W'(0));
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_out_data", out_data, p4(101, 101, 101, 101));
      check("bp_out_beat", W'(out_beat), W'(0));
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    wait_accept();
    send(p4(7, 7, 7, 7), p4(2, 2, 2, 2), 1, 0, p4(5, 5, 5, 5), 0, 0, 0);
    send(p4(7, 7, 7, 7), p4(2, 2, 2, 2), 0, 0, p4(5, 5, 5, 5), 1, 1, 0);

    // Reset mid-vector: partial vector discarded, next vector restarts at beat 0
    drain();
    out_ready = 0;
    send(p4(1, 1, 1, 1), p4(1, 1, 1, 1), 0, 0, p4(2, 2, 2, 2), 0, 0, 0);
    #1;
    rst_n = 0;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_out_data", out_data, '0);
    check("midrst_in_ready", W'(in_ready), W'(1));
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    out_ready = 1;
    send(p4(10, 20, 30, 40), p4(1, 2, 3, 4), 1, 0, p4(9, 18, 27, 36), 0, 0, 0);
    send(p4(50, 50, 50, 50), p4(5, 5, 5, 5), 0, 0, p4(45, 45, 45, 45), 1, 1, 0);
    drain();

    // Random valid/ready over 100 vectors against the model
    rand_ready = 1;
    for (int v = 0; v < 100; v++) begin
      vsub = 1'($urandom_range(0, 1));
      vsat = 1'($urandom_range(0, 1));
      acc  = 0;
      for (int bt = 0; bt < 2; bt++) begin
        for (int l = 0; l < LN; l++) begin
          case ($urandom_range(0, 4))
            0: begin ra[l*32 +: 32] = 32'h7fffffff; rb[l*32 +: 32] = $urandom_range(0, 3); end
            1: begin ra[l*32 +: 32] = 32'h80000000; rb[l*32 +: 32] = $urandom_range(0, 3); end
            2: begin ra[l*32 +: 32] = $urandom_range(0, 100); rb[l*32 +: 32] = 32'h80000000; end
            default: begin ra[l*32 +: 32] = $urandom; rb[l*32 +: 32] = $urandom; end
          endcase
        end
        model(ra, rb, vsub, vsat, rr, rov);
        acc |= rov;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        if (bt == 0) send(ra, rb, vsub, vsat, rr, 0, 0, 0);
        else send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rr, 1, 1, acc);
      end
    end
    rand_ready = 0;
    @(posedge clk);
    #2;
    out_ready = 1;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vector_add_stream.md
# vector_add_stream

Streaming, parametrised signed vector adder/subtractor. It accepts a VEC_LEN-element vector as a sequence of LANES-wide beats over a valid/ready handshake and emits the element-wise sum or difference one cycle later. Each beat is registered, with optional saturation and a per-vector overflow flag. It replaces fully-unrolled combinational vector adders in the datapath wherever operand vectors arrive from buffers or DMA in beats rather than as one flat bus.

## Interface
- DATA_W, 32, element width in bits, two's complement signed.
- VEC_LEN, 400, elements per vector. Must be a multiple of LANES; any other value is an elaboration error.
- LANES, 4, elements per beat.
- BEATS (localparam), VEC_LEN/LANES, beats per vector. BEAT_W = max(1, clog2(BEATS)).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept an input beat
- in_a  in  LANES*DATA_W  operand A lanes; lane i at bits [i*DATA_W +: DATA_W]
- in_b  in  LANES*DATA_W  operand B lanes, same packing as in_a
- op_sub  in  1  0 = A+B, 1 = A−B; sampled on the first beat of a vector only
- op_sat  in  1  0 = wrap, 1 = saturate; sampled on the first beat of a vector only
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the output beat
- out_data  out  LANES*DATA_W  result lanes, same packing as in_a
- out_beat  out  BEAT_W  beat index within the vector, 0..BEATS−1
- out_last  out  1  high on the final beat of the vector (out_beat == BEATS−1)
- out_ovf  out  1  valid only with out_last: at least one lane overflowed anywhere in this vector

## Operation
- Input transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- The block tracks two states using beat counter cnt:
  - IDLE (cnt == 0): the next transfer is beat 0. That transfer latches op_sub and op_sat into mode_q.
  - BUSY (cnt ≠ 0): beats 1..BEATS−1 use mode_q; op_sub and op_sat are ignored.
- Every transfer increments cnt. The transfer at cnt == BEATS−1 wraps cnt to 0 and returns to IDLE. With BEATS == 1, every beat is both first and last.
- Per-lane arithmetic:
  - Compute a DATA_W+1-bit exact result of a ± b.
  - Overflow is when the exact result falls outside [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Wrap mode: output the low DATA_W bits.
  - Saturate mode: clamp to max positive or min negative according to the sign of the exact result.
  - The overflow flag is raised in both modes.
- ovf_acc is a sticky OR of all lane overflows of all beats in the current vector. out_ovf = ovf_acc including the final beat. ovf_acc clears when the last beat transfers in.
- Unused upper out_beat bits are 0.

## Timing
- The output is a single register stage. in_ready = !out_valid || out_ready, so full throughput of one beat per cycle is sustained while out_ready is high.
- Latency: an input transfer at edge N gives out_valid high and the data visible after edge N, so it is consumed on edge N+1 or later.
- While out_valid && !out_ready:
  - out_data, out_beat, out_last and out_ovf hold stable.
  - in_ready is low.
  - No input beat is lost or duplicated.
- Simultaneous output and input transfer in the same cycle: the register reloads with the new beat, and out_valid stays high.
- in_valid may drop between beats of a vector. cnt and mode_q hold across the gaps.
- Reset values (asynchronous, on rst_n low):
  - out_valid 0, out_data 0, out_beat 0, out_last 0, out_ovf 0.
  - cnt 0, mode_q 0, ovf_acc 0.
  - in_ready 1 after release.
- Reset mid-vector: the partial vector is discarded. The first beat after release is beat 0 and re-samples the mode.
- No combinational path from in_valid, in_a or in_b to any output. in_ready depends combinationally on out_ready only.

## Test plan
- Wrap add, DATA_W=32, VEC_LEN=8, LANES=4, out_ready=1: beats a={1,2,3,4},{5,6,7,8}, b={10,…}. Required: out_data={11,12,13,14},{15,16,17,18}, out_beat 0 then 1, out_last on beat 1, out_ovf=0, one cycle latency.
- Saturate add: lane a=0x7FFFFFFF, b=1 gives 0x7FFFFFFF. Saturate sub: a=0x80000000 minus b=1 gives 0x80000000. out_ovf=1 on the last beat even though overflow happened on beat 0.
- Wrap overflow: a=0x7FFFFFFF + 1 gives 0x80000000 and out_ovf=1. The next vector with no overflow reports out_ovf=0.
- Mode lock: op_sub=1 on beat 0, toggled to 0 on beat 1. Both beats are subtracted.
- Backpressure: out_ready held low for 3 cycles while in_valid=1. Required: in_ready=0, outputs stable, and the full sequence is delivered in order with no drop or duplication. Also drive random valid/ready over 100 vectors and check against a reference model.
- Reset mid-vector: assert rst_n=0 after beat 0 of 2. Required: outputs clear immediately. After release, a new vector with op_sub=1 is subtracted and starts at out_beat 0.
